// File: rtl/uart_tx_scheduler_if.sv
// Bundles the source side (req/req_data/grant_ack) and the transmitter side
// (tx_data/tx_wr_en/tx_busy) of uart_tx_scheduler. master = scheduler, slave = sources + uart_tx.
interface uart_tx_scheduler_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_CH-1:0]            req;
    logic [NUM_CH*DATA_WIDTH-1:0] req_data;
    logic [NUM_CH-1:0]            grant_ack;
    logic [DATA_WIDTH-1:0]        tx_data;
    logic                         tx_wr_en;
    logic                         tx_busy;

    modport master (
        input  req, req_data, tx_busy,
        output grant_ack, tx_data, tx_wr_en
    );

    modport slave (
        output req, req_data, tx_busy,
        input  grant_ack, tx_data, tx_wr_en
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx among NUM_CH FIFO sources; one word in flight at a time.
// Optional UART_SCHED_TAG_EN: each data word is preceded by a channel tag word {0, TAG_BASE | ch}.
module uart_tx_scheduler #(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_WIDTH = 16,
    parameter logic [7:0]  TAG_BASE   = 8'hF0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    uart_tx_scheduler_if.master bus,
    output logic [2:0]          active_ch,
    output logic                sched_busy,
    output logic [15:0]         frame_cnt,
    output logic                stall_err,
    output logic [3:0]          dbg_state
);
    // Handshakes: grant_ack is a one-cycle pop strobe, req_data is valid the cycle after it;
    // tx_wr_en is a one-cycle load strobe and tx_busy must rise within the start window.
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        POP        = 4'd1,
        LOAD       = 4'd2,
        ISSUE      = 4'd3,
        WAIT_START = 4'd4,
        WAIT_DONE  = 4'd5
`ifdef UART_SCHED_TAG_EN
        ,
        TAG        = 4'd6,
        TAG_START  = 4'd7,
        TAG_DONE   = 4'd8
`endif
    } state_t;

    state_t                state, state_next;
    logic [1:0]            tmo, tmo_next;
    logic [2:0]            last;
    logic [2:0]            winner, win_hi, win_lo;
    logic                  found_hi, found_lo, any_req;
    logic [NUM_CH-1:0]     grant_vec;
    logic [DATA_WIDTH-1:0] slice;
    logic                  take, timeout, frame_inc, wr_next;
`ifdef UART_SCHED_TAG_EN
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] tag_word;
    assign tag_word = DATA_WIDTH'(TAG_BASE | {5'b0, active_ch});
`endif

    assign dbg_state = state;
    assign any_req   = |bus.req;

    // Descending scan so the lowest index in each half wins: above-pointer half first, then wrap.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (bus.req[c]) begin
                if (3'(c) > last) begin
                    found_hi = 1'b1;
                    win_hi   = 3'(c);
                end else begin
                    found_lo = 1'b1;
                    win_lo   = 3'(c);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        grant_vec = '0;
        slice     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            grant_vec[c] = (winner == 3'(c));
            if (active_ch == 3'(c)) slice = bus.req_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_next = state;
        tmo_next   = '0;
        take       = 1'b0;
        timeout    = 1'b0;
        frame_inc  = 1'b0;
        wr_next    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && any_req && !bus.tx_busy) begin
                    take       = 1'b1;
                    state_next = POP;
                end
            end
            POP: state_next = LOAD;
            LOAD: begin
                wr_next = 1'b1;
`ifdef UART_SCHED_TAG_EN
                state_next = TAG;
`else
                state_next = ISSUE;
`endif
            end
            ISSUE: state_next = WAIT_START;
            // Start window: the issue cycle plus three waiting cycles without busy.
            WAIT_START: begin
                if (bus.tx_busy)           state_next = WAIT_DONE;
                else if (tmo == 2'd2) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else                   tmo_next   = tmo + 2'd1;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    frame_inc  = 1'b1;
                    state_next = IDLE;
                end
            end
`ifdef UART_SCHED_TAG_EN
            TAG: state_next = TAG_START;
            TAG_START: begin
                if (bus.tx_busy)           state_next = TAG_DONE;
                else if (tmo == 2'd2) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else                   tmo_next   = tmo + 2'd1;
            end
            TAG_DONE: begin
                if (!bus.tx_busy) begin
                    wr_next    = 1'b1;
                    state_next = ISSUE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            tmo           <= '0;
            last          <= 3'(NUM_CH - 1);
            active_ch     <= '0;
            bus.grant_ack <= '0;
            bus.tx_data   <= '0;
            bus.tx_wr_en  <= 1'b0;
            sched_busy    <= 1'b0;
            frame_cnt     <= '0;
            stall_err     <= 1'b0;
`ifdef UART_SCHED_TAG_EN
            hold          <= '0;
`endif
        end else begin
            state         <= state_next;
            tmo           <= tmo_next;
            bus.grant_ack <= take ? grant_vec : '0;
            bus.tx_wr_en  <= wr_next;
            sched_busy    <= (state_next != IDLE);
            if (take) begin
                active_ch <= winner;
                last      <= winner;
            end
`ifdef UART_SCHED_TAG_EN
            if (state == LOAD) begin
                bus.tx_data <= tag_word;
                hold        <= slice;
            end
            if (state == TAG_DONE && wr_next) bus.tx_data <= hold;
`else
            if (state == LOAD) bus.tx_data <= slice;
`endif
            if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
            if (timeout)   stall_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with FIFO-source and uart_tx busy models.
module tb_uart_tx_scheduler;
  localparam int NUM_CH = 4;
  localparam int DW     = 16;
`ifdef UART_SCHED_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif
  localparam int TD = TAG_ON ? 102 : 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  active_ch;
  logic        sched_busy;
  logic [15:0] frame_cnt;
  logic        stall_err;
  logic [3:0]  dbg_state;

  uart_tx_scheduler_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

  uart_tx_scheduler #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TAG_BASE(8'hF0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .active_ch(active_ch), .sched_busy(sched_busy), .frame_cnt(frame_cnt),
    .stall_err(stall_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int gnt_q[$];
  logic [DW-1:0] fq[NUM_CH][$];
  int busy_len = 5;
  bit busy_dead = 1'b0;
  int busy_cnt;

  // FIFO sources with registered outputs
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.grant_ack[c] && fq[c].size() > 0) bus.req_data[c*DW +: DW] <= fq[c].pop_front();
      bus.req[c] <= (fq[c].size() > 0);
    end
  end

  // uart_tx busy model: busy for busy_len cycles starting the cycle after the load strobe
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_cnt <= 0;
      bus.tx_busy <= 1'b0;
    end else if (bus.tx_wr_en && !busy_dead) begin
      busy_cnt <= busy_len;
      bus.tx_busy <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      bus.tx_busy <= 1'b0;
    end
  end

  // monitor
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.tx_wr_en) got_q.push_back(bus.tx_data);
      for (int c = 0; c < NUM_CH; c++) if (bus.grant_ack[c]) gnt_q.push_back(c);
    end
  end

  // driver: load a word into a source and record the expected transmit sequence
  task automatic push_word(input int c, input logic [DW-1:0] w);
    fq[c].push_back(w);
    if (TAG_ON) exp_q.push_back(16'h00F0 | DW'(c));
    exp_q.push_back(w);
  endtask

  task automatic clear_logs;
    exp_q.delete();
    got_q.delete();
    gnt_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.grant_ack !== 4'b0) begin n_fail++; $display("FAIL reset_grant_ack got=%b exp=0000", bus.grant_ack); end
    n_checks++; if (bus.tx_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_wr_en got=%b exp=0", bus.tx_wr_en); end
    n_checks++; if (bus.tx_data !== 16'h0) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=0000", bus.tx_data); end
    n_checks++; if (active_ch !== 3'd0) begin n_fail++; $display("FAIL reset_active_ch got=%0d exp=0", active_ch); end
    n_checks++; if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL reset_sched_busy got=%b exp=0", sched_busy); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    n_checks++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL reset_stall_err got=%b exp=0", stall_err); end
    n_checks++; if (dbg_state !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    clear_logs();
    busy_len = 100;
    push_word(0, 16'h0041);
    @(negedge clk); // N: req visible
    n_checks++; if (bus.grant_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_N got=%b exp=0000", bus.grant_ack); end
    @(negedge clk); // N+1
    n_checks++; if (bus.grant_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack_N1 got=%b exp=0001", bus.grant_ack); end
    n_checks++; if (sched_busy !== 1'b1) begin n_fail++; $display("FAIL single_sched_busy got=%b exp=1", sched_busy); end
    @(negedge clk); // N+2
    n_checks++; if (bus.grant_ack !== 4'b0000 || bus.tx_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_N2 ack=%b wr=%b exp ack=0000 wr=0", bus.grant_ack, bus.tx_wr_en); end
    @(negedge clk); // N+3
    n_checks++; if (bus.tx_wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_N3 got=%b exp=1", bus.tx_wr_en); end
    n_checks++; if (bus.tx_data !== (TAG_ON ? 16'h00F0 : 16'h0041)) begin n_fail++; $display("FAIL single_data_N3 got=%h exp=%h", bus.tx_data, (TAG_ON ? 16'h00F0 : 16'h0041)); end
    repeat (101 + TD) @(negedge clk); // N+104+TD: busy just dropped
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL single_cnt_early got=%0d exp=0", frame_cnt); end
    @(negedge clk);
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt got=%0d exp=1", frame_cnt); end
    n_checks++; if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", sched_busy); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_sb_size got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_sb[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin;
    int acks[NUM_CH];
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    busy_len = 5;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NUM_CH; c++) push_word(c, 16'((c << 8) | r));
    for (int i = 0; i < 3000 && !(frame_cnt == 16'd16 && !sched_busy); i++) @(negedge clk);
    n_checks++; if (frame_cnt !== 16'd16) begin n_fail++; $display("FAIL rr_frame_cnt got=%0d exp=16", frame_cnt); end
    for (int c = 0; c < NUM_CH; c++) acks[c] = 0;
    foreach (gnt_q[i]) acks[gnt_q[i]]++;
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++; if (acks[c] !== 4) begin n_fail++; $display("FAIL rr_acks_ch%0d got=%0d exp=4", c, acks[c]); end
    end
    for (int i = 0; i < 16 && i < gnt_q.size(); i++) begin
      n_checks++; if (gnt_q[i] !== (i % 4)) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, gnt_q[i], i % 4); end
    end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rr_sb_size got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_sb[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL rr_stall got=%b exp=0", stall_err); end
  endtask

  task automatic test_pattern_1010;
    clear_logs();
    push_word(1, 16'h1111);
    for (int i = 0; i < 500 && !(frame_cnt == 16'd17 && !sched_busy); i++) @(negedge clk);
    push_word(3, 16'h3333);
    push_word(1, 16'h1122);
    for (int i = 0; i < 1000 && !(frame_cnt == 16'd19 && !sched_busy); i++) @(negedge clk);
    n_checks++; if (frame_cnt !== 16'd19) begin n_fail++; $display("FAIL p1010_frame_cnt got=%0d exp=19", frame_cnt); end
    n_checks++; if (gnt_q.size() !== 3) begin n_fail++; $display("FAIL p1010_gnt_size got=%0d exp=3", gnt_q.size()); end
    if (gnt_q.size() == 3) begin
      n_checks++; if (gnt_q[1] !== 3) begin n_fail++; $display("FAIL p1010_second got=%0d exp=3", gnt_q[1]); end
      n_checks++; if (gnt_q[2] !== 1) begin n_fail++; $display("FAIL p1010_third got=%0d exp=1", gnt_q[2]); end
    end
    n_checks++; if (active_ch !== 3'd1) begin n_fail++; $display("FAIL p1010_active_ch got=%0d exp=1", active_ch); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL p1010_sb_size got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL p1010_sb[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall;
    clear_logs();
    busy_dead = 1'b1;
    fq[0].push_back(16'h0BAD);
    exp_q.push_back(TAG_ON ? 16'h00F0 : 16'h0BAD); // tag timeout drops the data word
    for (int i = 0; i < 20 && bus.tx_wr_en !== 1'b1; i++) @(negedge clk);
    n_checks++; if (bus.tx_wr_en !== 1'b1) begin n_fail++; $display("FAIL stall_issue_seen got=%b exp=1", bus.tx_wr_en); end
    repeat (3) @(negedge clk); // M+3
    n_checks++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL stall_early got=%b exp=0", stall_err); end
    @(negedge clk); // M+4
    n_checks++; if (stall_err !== 1'b1) begin n_fail++; $display("FAIL stall_set got=%b exp=1", stall_err); end
    n_checks++; if (dbg_state !== 4'd0) begin n_fail++; $display("FAIL stall_state got=%0d exp=0", dbg_state); end
    n_checks++; if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL stall_sched_busy got=%b exp=0", sched_busy); end
    n_checks++; if (frame_cnt !== 16'd19) begin n_fail++; $display("FAIL stall_frame_cnt got=%0d exp=19", frame_cnt); end
    busy_dead = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (stall_err !== 1'b1) begin n_fail++; $display("FAIL stall_sticky got=%b exp=1", stall_err); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_sb_size got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_sb[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    clear_logs();
    busy_len = 50;
    fq[1].push_back(16'h2222);
    for (int i = 0; i < 300 && dbg_state !== 4'd5; i++) @(negedge clk);
    n_checks++; if (dbg_state !== 4'd5) begin n_fail++; $display("FAIL rmid_reach_wait_done got=%0d exp=5", dbg_state); end
    rst_n = 1'b0;
    clear_logs();
    push_word(0, 16'hA000);
    push_word(2, 16'hC000);
    @(negedge clk);
    n_checks++; if (bus.grant_ack !== 4'b0 || bus.tx_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_strobes ack=%b wr=%b exp ack=0000 wr=0", bus.grant_ack, bus.tx_wr_en); end
    n_checks++; if (bus.tx_data !== 16'h0 || active_ch !== 3'd0) begin n_fail++; $display("FAIL rmid_data data=%h ch=%0d exp data=0000 ch=0", bus.tx_data, active_ch); end
    n_checks++; if (sched_busy !== 1'b0 || dbg_state !== 4'd0) begin n_fail++; $display("FAIL rmid_state busy=%b state=%0d exp busy=0 state=0", sched_busy, dbg_state); end
    n_checks++; if (frame_cnt !== 16'd0 || stall_err !== 1'b0) begin n_fail++; $display("FAIL rmid_status cnt=%0d stall=%b exp cnt=0 stall=0", frame_cnt, stall_err); end
    rst_n = 1'b1;
    busy_len = 5;
    for (int i = 0; i < 500 && !(frame_cnt == 16'd2 && !sched_busy); i++) @(negedge clk);
    n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL rmid_frame_cnt got=%0d exp=2", frame_cnt); end
    n_checks++; if (gnt_q.size() < 1 || gnt_q[0] !== 0) begin n_fail++; $display("FAIL rmid_first_grant got=%0d exp=0", (gnt_q.size() > 0) ? gnt_q[0] : -1); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rmid_sb_size got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_sb[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_tag;
    clear_logs();
    push_word(2, 16'h0055);
    for (int i = 0; i < 500 && !(frame_cnt == 16'd3 && !sched_busy); i++) @(negedge clk);
    n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL tag_frame_cnt got=%0d exp=3", frame_cnt); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL tag_sb_size got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tag_sb[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (active_ch !== 3'd2) begin n_fail++; $display("FAIL tag_active_ch got=%0d exp=2", active_ch); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pattern_1010();
    test_stall();
    test_reset_mid();
    test_tag();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
